sgpr_rd_port_arbiter: RTL and testbench
=======================================

SGPR_RD_PORT_ARBITER -- requirements
Module: sgpr_rd_port_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, cycles from portN_rd_en to valid rd_data at the SGPR read mux; legal range 1..4.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports reqN_valid (N=0..7), input, 1 each, client N requests an SGPR read.
REQ-005 SHALL have ports reqN_addr (N=0..7), input, 9 each, SGPR address for client N, valid while reqN_valid=1.
REQ-006 SHALL have ports reqN_ack (N=0..7), output, 1 each, request N accepted this cycle.
REQ-007 SHALL have ports portN_rd_en (N=0..7), output, 1 each, registered read enable toward the SGPR read mux, at most one high per cycle.
REQ-008 SHALL have ports portN_rd_addr (N=0..7), output, 9 each, registered address toward the SGPR read mux.
REQ-009 SHALL have port port_rd_data, input, 32, read data returned by the SGPR read mux.
REQ-010 SHALL have port resp_valid, output, 8, one-hot, client whose data is on resp_data.
REQ-011 SHALL have port resp_data, output, 32, read data for the client flagged by resp_valid.

Function
REQ-012 SHALL arbitrate round-robin among asserted reqN_valid using a 3-bit priority pointer; the pointer index has highest priority, then ascending with wrap 7->0.
REQ-013 SHALL assert reqN_ack combinationally, in cycle T only, for the single winner; at most one ack per cycle.
REQ-014 SHALL, on a grant in cycle T, assert portN_rd_en=1 and portN_rd_addr=reqN_addr(T) for exactly cycle T+1; all other portM_rd_en=0.
REQ-015 SHALL hold portN_rd_addr at its last value while portN_rd_en=0.
REQ-016 SHALL update the pointer to (winner+1) mod 8 after each grant: winner 7 -> pointer 0. The pointer SHALL be unchanged in cycles with no grant.
REQ-017 SHALL sustain one grant per cycle; a continuously requesting client is granted at least once every 8 cycles.
REQ-018 SHALL carry the one-hot grant vector down a RD_LATENCY+1 stage shift register; resp_valid is the grant vector delayed to cycle T+1+RD_LATENCY, with resp_data=port_rd_data in that cycle.
REQ-019 SHALL pass resp_data through combinationally from port_rd_data; it is don't-care when resp_valid=0.
REQ-020 SHALL let a client deassert reqN_valid before ack with no side effect; an acked request SHALL always produce exactly one response.
REQ-021 SHALL sample a client's new request in the cycle after its ack, if reqN_valid is held; each held cycle is a distinct request.
REQ-022 SHALL leave the pointer unchanged and all outputs low when no request is asserted.

Reset
REQ-023 SHALL, while rst=0, force all reqN_ack, portN_rd_en and resp_valid to 0, portN_rd_addr to 0 and the pointer to 0.
REQ-024 SHALL, on assertion of rst mid-operation, discard all in-flight grants; no resp_valid follows for requests acked before reset.
REQ-025 SHALL grant no request in the first cycle after rst deasserts, then arbitrate normally.

Configuration
REQ-026 SHALL, with macro SGPR_RD_ARB_PERF_EN defined, add outputs perf_grants (32-bit, +1 per grant) and perf_conflicts (32-bit, +1 per cycle with >=2 reqN_valid); both wrap at 2^32 and reset to 0.
REQ-027 SHALL, without SGPR_RD_ARB_PERF_EN, omit both ports and counters; behaviour is otherwise identical.

Verification
REQ-028 SHALL cover a single read: req3_valid=1, addr=0x1A5 at T -> req3_ack at T; port3_rd_en=1, addr 0x1A5 at T+1; resp_valid=8'h08 at T+2 (RD_LATENCY=1).
REQ-029 SHALL cover all eight clients continuously requesting from reset -> grants in order 0,1,...,7,0; exactly one portN_rd_en per cycle.
REQ-030 SHALL cover wrap: grant to 7, then req0 and req6 together -> 0 wins, then 6.
REQ-031 SHALL cover RD_LATENCY=3 with back-to-back grants 2,5 at T, T+1 -> resp_valid 8'h04 at T+4, 8'h20 at T+5, data matched.
REQ-032 SHALL cover rst asserted at T+1 after grant at T -> no resp_valid afterwards; pointer 0; first grant two cycles after release.
REQ-033 SHALL cover, with SGPR_RD_ARB_PERF_EN, 10 cycles of 3 simultaneous requests -> perf_grants=10, perf_conflicts=10.

Source files
------------

// File: rtl/sgpr_rd_port_arbiter.sv
// Eight-client round-robin read arbiter in front of the SGPR read mux, with a
// grant pipeline that tags returning data. Optional counters: SGPR_RD_ARB_PERF_EN.
module sgpr_rd_port_arbiter #(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   input  logic        req2_valid,
   input  logic        req3_valid,
   input  logic        req4_valid,
   input  logic        req5_valid,
   input  logic        req6_valid,
   input  logic        req7_valid,
   input  logic [8:0]  req0_addr,
   input  logic [8:0]  req1_addr,
   input  logic [8:0]  req2_addr,
   input  logic [8:0]  req3_addr,
   input  logic [8:0]  req4_addr,
   input  logic [8:0]  req5_addr,
   input  logic [8:0]  req6_addr,
   input  logic [8:0]  req7_addr,
   output logic        req0_ack,
   output logic        req1_ack,
   output logic        req2_ack,
   output logic        req3_ack,
   output logic        req4_ack,
   output logic        req5_ack,
   output logic        req6_ack,
   output logic        req7_ack,
   output logic        port0_rd_en,
   output logic        port1_rd_en,
   output logic        port2_rd_en,
   output logic        port3_rd_en,
   output logic        port4_rd_en,
   output logic        port5_rd_en,
   output logic        port6_rd_en,
   output logic        port7_rd_en,
   output logic [8:0]  port0_rd_addr,
   output logic [8:0]  port1_rd_addr,
   output logic [8:0]  port2_rd_addr,
   output logic [8:0]  port3_rd_addr,
   output logic [8:0]  port4_rd_addr,
   output logic [8:0]  port5_rd_addr,
   output logic [8:0]  port6_rd_addr,
   output logic [8:0]  port7_rd_addr,
   input  logic [31:0] port_rd_data,
   output logic [7:0]  resp_valid,
   output logic [31:0] resp_data
`ifdef SGPR_RD_ARB_PERF_EN
   ,
   output logic [31:0] perf_grants,
   output logic [31:0] perf_conflicts
`endif
);

   logic [7:0] valid;
   logic [8:0] addr   [8];
   logic [8:0] addr_q [8];
   logic [7:0] pipe_q [RD_LATENCY+1];
   logic [7:0] grant;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] idx, win;
   logic       any;
   logic       run_q;

   assign valid = {req7_valid, req6_valid, req5_valid, req4_valid,
                   req3_valid, req2_valid, req1_valid, req0_valid};
   assign addr[0] = req0_addr;
   assign addr[1] = req1_addr;
   assign addr[2] = req2_addr;
   assign addr[3] = req3_addr;
   assign addr[4] = req4_addr;
   assign addr[5] = req5_addr;
   assign addr[6] = req6_addr;
   assign addr[7] = req7_addr;

   // Scan from the pointer upward with 3-bit wrap; run_q blocks the first cycle out of reset.
   always_comb begin
      any   = 1'b0;
      win   = '0;
      idx   = '0;
      grant = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         idx = ptr_q + 3'(i);
         if (!any && run_q && valid[idx]) begin
            any = 1'b1;
            win = idx;
         end
      end
      if (any) grant = 8'd1 << win;
      ptr_d = any ? win + 3'd1 : ptr_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q <= 1'b0;
         ptr_q <= '0;
         for (int unsigned k = 0; k <= RD_LATENCY; k++) pipe_q[k] <= '0;
         for (int unsigned n = 0; n < 8; n++) addr_q[n] <= '0;
      end else begin
         run_q     <= 1'b1;
         ptr_q     <= ptr_d;
         pipe_q[0] <= grant;
         for (int unsigned k = 1; k <= RD_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
         for (int unsigned n = 0; n < 8; n++)
            if (grant[n]) addr_q[n] <= addr[n];
      end
   end

   assign {req7_ack, req6_ack, req5_ack, req4_ack,
           req3_ack, req2_ack, req1_ack, req0_ack} = grant;
   // Stage 0 of the grant pipe is the registered read enable itself.
   assign {port7_rd_en, port6_rd_en, port5_rd_en, port4_rd_en,
           port3_rd_en, port2_rd_en, port1_rd_en, port0_rd_en} = pipe_q[0];
   assign port0_rd_addr = addr_q[0];
   assign port1_rd_addr = addr_q[1];
   assign port2_rd_addr = addr_q[2];
   assign port3_rd_addr = addr_q[3];
   assign port4_rd_addr = addr_q[4];
   assign port5_rd_addr = addr_q[5];
   assign port6_rd_addr = addr_q[6];
   assign port7_rd_addr = addr_q[7];
   assign resp_valid    = pipe_q[RD_LATENCY];
   assign resp_data     = port_rd_data;

`ifdef SGPR_RD_ARB_PERF_EN
   logic [31:0] grants_q, conflicts_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grants_q    <= '0;
         conflicts_q <= '0;
      end else begin
         if (any) grants_q <= grants_q + 32'd1;
         if ($countones(valid) > 1) conflicts_q <= conflicts_q + 32'd1;
      end
   end

   assign perf_grants    = grants_q;
   assign perf_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// Bench for sgpr_rd_port_arbiter: one instance at RD_LATENCY=1 and one at 3 share
// request inputs; a vector table drives requests, queues predict responses.
module tb_sgpr_rd_port_arbiter;

   typedef struct {
      logic [7:0] v;
      logic [7:0] ack;
      logic       rn;
      logic       pin;
   } row_t;

   typedef struct packed {
      int         due;
      logic [7:0] vec;
   } sb_t;

   logic        clk;
   logic        rst;
   logic [7:0]  valid;
   logic [8:0]  addr_in [8];
   logic [31:0] rd_data1, rd_data3;
   logic        pin3;

   wire [7:0]  ack1, en1, rv1, ack3, en3, rv3;
   wire [71:0] ra1, ra3;
   wire [31:0] rdat1, rdat3;

   int         cyc, errors, checks;
   logic [7:0] exp_en;
   logic [71:0] exp_ra;
   sb_t        q1[$], q3[$];
   row_t       tbl[$];

   sgpr_rd_port_arbiter #(.RD_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(valid[0]), .req1_valid(valid[1]), .req2_valid(valid[2]), .req3_valid(valid[3]),
      .req4_valid(valid[4]), .req5_valid(valid[5]), .req6_valid(valid[6]), .req7_valid(valid[7]),
      .req0_addr(addr_in[0]), .req1_addr(addr_in[1]), .req2_addr(addr_in[2]), .req3_addr(addr_in[3]),
      .req4_addr(addr_in[4]), .req5_addr(addr_in[5]), .req6_addr(addr_in[6]), .req7_addr(addr_in[7]),
      .req0_ack(ack1[0]), .req1_ack(ack1[1]), .req2_ack(ack1[2]), .req3_ack(ack1[3]),
      .req4_ack(ack1[4]), .req5_ack(ack1[5]), .req6_ack(ack1[6]), .req7_ack(ack1[7]),
      .port0_rd_en(en1[0]), .port1_rd_en(en1[1]), .port2_rd_en(en1[2]), .port3_rd_en(en1[3]),
      .port4_rd_en(en1[4]), .port5_rd_en(en1[5]), .port6_rd_en(en1[6]), .port7_rd_en(en1[7]),
      .port0_rd_addr(ra1[8:0]),   .port1_rd_addr(ra1[17:9]),  .port2_rd_addr(ra1[26:18]),
      .port3_rd_addr(ra1[35:27]), .port4_rd_addr(ra1[44:36]), .port5_rd_addr(ra1[53:45]),
      .port6_rd_addr(ra1[62:54]), .port7_rd_addr(ra1[71:63]),
      .port_rd_data(rd_data1), .resp_valid(rv1), .resp_data(rdat1)
   );

   sgpr_rd_port_arbiter #(.RD_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0_valid(valid[0]), .req1_valid(valid[1]), .req2_valid(valid[2]), .req3_valid(valid[3]),
      .req4_valid(valid[4]), .req5_valid(valid[5]), .req6_valid(valid[6]), .req7_valid(valid[7]),
      .req0_addr(addr_in[0]), .req1_addr(addr_in[1]), .req2_addr(addr_in[2]), .req3_addr(addr_in[3]),
      .req4_addr(addr_in[4]), .req5_addr(addr_in[5]), .req6_addr(addr_in[6]), .req7_addr(addr_in[7]),
      .req0_ack(ack3[0]), .req1_ack(ack3[1]), .req2_ack(ack3[2]), .req3_ack(ack3[3]),
      .req4_ack(ack3[4]), .req5_ack(ack3[5]), .req6_ack(ack3[6]), .req7_ack(ack3[7]),
      .port0_rd_en(en3[0]), .port1_rd_en(en3[1]), .port2_rd_en(en3[2]), .port3_rd_en(en3[3]),
      .port4_rd_en(en3[4]), .port5_rd_en(en3[5]), .port6_rd_en(en3[6]), .port7_rd_en(en3[7]),
      .port0_rd_addr(ra3[8:0]),   .port1_rd_addr(ra3[17:9]),  .port2_rd_addr(ra3[26:18]),
      .port3_rd_addr(ra3[35:27]), .port4_rd_addr(ra3[44:36]), .port5_rd_addr(ra3[53:45]),
      .port6_rd_addr(ra3[62:54]), .port7_rd_addr(ra3[71:63]),
      .port_rd_data(rd_data3), .resp_valid(rv3), .resp_data(rdat3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] v, input logic [7:0] ack, input logic rn, input logic pin);
      row_t r;
      r.v = v; r.ack = ack; r.rn = rn; r.pin = pin;
      tbl.push_back(r);
   endtask

   // Entered at the falling edge of cycle cyc; leaves at the falling edge of cyc+1.
   task automatic step(input logic [7:0] v, input logic [7:0] ea, input logic rn, input logic pin);
      logic [7:0] er1, er3;
      chk("rd_en_lat1", {64'd0, en1}, {64'd0, exp_en});
      chk("rd_en_lat3", {64'd0, en3}, {64'd0, exp_en});
      chk("rd_addr_lat1", ra1, exp_ra);
      chk("rd_addr_lat3", ra3, exp_ra);
      er1 = '0;
      er3 = '0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
         er1 = q1[0].vec;
         void'(q1.pop_front());
      end
      if (q3.size() > 0 && q3[0].due == cyc) begin
         er3 = q3[0].vec;
         void'(q3.pop_front());
      end
      chk("resp_valid_lat1", {64'd0, rv1}, {64'd0, er1});
      chk("resp_valid_lat3", {64'd0, rv3}, {64'd0, er3});

      rst   = rn;
      valid = v;
      for (int i = 0; i < 8; i++) addr_in[i] = 9'($urandom_range(0, 511));
      if (pin) addr_in[3] = 9'h1A5;
      rd_data1 = $urandom;
      rd_data3 = $urandom;
      #1;
      chk("ack_lat1", {64'd0, ack1}, {64'd0, ea});
      chk("ack_lat3", {64'd0, ack3}, {64'd0, ea});
      if (er1 != 8'd0) chk("resp_data_lat1", {40'd0, rdat1}, {40'd0, rd_data1});
      if (er3 != 8'd0) chk("resp_data_lat3", {40'd0, rdat3}, {40'd0, rd_data3});

      if (!rn) begin
         q1.delete();
         q3.delete();
         exp_en = '0;
         exp_ra = '0;
      end else begin
         exp_en = ea;
         for (int i = 0; i < 8; i++)
            if (ea[i]) exp_ra[i*9 +: 9] = addr_in[i];
         if (ea != 8'd0) begin
            q1.push_back('{due: cyc + 2, vec: ea});
            q3.push_back('{due: cyc + 4, vec: ea});
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      exp_en = '0; exp_ra = '0;
      valid = '0; pin3 = 1'b0;
      rd_data1 = '0; rd_data3 = '0;
      for (int i = 0; i < 8; i++) addr_in[i] = '0;
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);

      // reset held with every client requesting, then release: no grant that cycle
      add(8'hFF, 8'h00, 1'b0, 1'b0);
      add(8'hFF, 8'h00, 1'b0, 1'b0);
      add(8'hFF, 8'h00, 1'b1, 1'b0);
      // all eight continuously requesting: 0..7 then 0 again (pointer ends at 1)
      add(8'hFF, 8'h01, 1'b1, 1'b0);
      add(8'hFF, 8'h02, 1'b1, 1'b0);
      add(8'hFF, 8'h04, 1'b1, 1'b0);
      add(8'hFF, 8'h08, 1'b1, 1'b0);
      add(8'hFF, 8'h10, 1'b1, 1'b0);
      add(8'hFF, 8'h20, 1'b1, 1'b0);
      add(8'hFF, 8'h40, 1'b1, 1'b0);
      add(8'hFF, 8'h80, 1'b1, 1'b0);
      add(8'hFF, 8'h01, 1'b1, 1'b0);
      // wrap: grant 7, then 0 and 6 together -> 0 then 6 (pointer ends at 7)
      add(8'h80, 8'h80, 1'b1, 1'b0);
      add(8'h41, 8'h01, 1'b1, 1'b0);
      add(8'h41, 8'h40, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) add(8'h00, 8'h00, 1'b1, 1'b0);
      // single read, client 3 at 0x1A5 (pointer ends at 4)
      add(8'h08, 8'h08, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) add(8'h00, 8'h00, 1'b1, 1'b0);
      // 2 and 5 compete from pointer 4 -> 5; client 2 then withdraws unacked
      add(8'h24, 8'h20, 1'b1, 1'b0);
      add(8'h00, 8'h00, 1'b1, 1'b0);
      // back-to-back grants 2 then 5 (pointer 6 wraps to 2)
      add(8'h24, 8'h04, 1'b1, 1'b0);
      add(8'h20, 8'h20, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 1'b1, 1'b0);
      // held request: each held cycle is a new grant; then 1,2 contention from pointer 2 and 3
      add(8'h02, 8'h02, 1'b1, 1'b0);
      add(8'h02, 8'h02, 1'b1, 1'b0);
      add(8'h02, 8'h02, 1'b1, 1'b0);
      add(8'h06, 8'h04, 1'b1, 1'b0);
      add(8'h06, 8'h02, 1'b1, 1'b0);
      add(8'h06, 8'h04, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) add(8'h00, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i].v, tbl[i].ack, tbl[i].rn, tbl[i].pin);

      // reset one cycle after a grant: in-flight response must vanish, pointer back to 0
      step(8'h08, 8'h08, 1'b1, 1'b0);
      step(8'hFF, 8'h00, 1'b0, 1'b0);
      step(8'hFF, 8'h00, 1'b0, 1'b0);
      step(8'hFF, 8'h00, 1'b1, 1'b0);
      step(8'hFF, 8'h01, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(8'h00, 8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
